// File: rtl/bus_sram_slave.sv
// bus_sram_slave: word-addressed SRAM target on the shared system bus.
// Decodes a fixed address window, serves single/burst reads and writes,
// and pulses a bus error for bursts that would run past the window end.
// Every output is zero while the block is not driving, so it can be
// OR'd onto the bus with the other agents.
module bus_sram_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          DEPTH_WORDS  = 256,
    parameter int          READ_LATENCY = 2,
    parameter int          WR_STALL     = 0
) (
    input  logic        sb_clock_i,
    input  logic        sb_reset_n_i,
    input  logic        sb_begin_transaction_i,
    input  logic        sb_end_transaction_i,
    input  logic        sb_data_valid_i,
    input  logic        sb_read_n_write_i,
    input  logic [31:0] sb_address_data_i,
    input  logic [3:0]  sb_byte_enables_i,
    input  logic [7:0]  sb_burst_size_i,
    input  logic        sb_error_i,
    output logic [31:0] sb_address_data_o,
    output logic        sb_data_valid_o,
    output logic        sb_end_transaction_o,
    output logic        sb_busy_o,
    output logic        sb_error_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LO_WORD   = BASE_ADDR >> 2;
    localparam logic [31:0] HI_WORD   = LO_WORD + 32'(DEPTH_WORDS);
    localparam logic [15:0] DEPTH16   = 16'(DEPTH_WORDS);
    // RD_WAIT is skipped entirely when the latency is a single cycle.
    localparam logic [3:0]  WAIT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, ERR} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic [8:0]      r_left;
    logic [3:0]      r_cnt;
    logic [3:0]      r_be;
    logic            r_dv;
    logic            r_end;
    logic            r_busy;
    logic            r_err;

    logic [31:0]     w_addr_word;
    logic            w_sel;
    logic [AW-1:0]   w_in_idx;
    logic [8:0]      w_beats;
    logic [15:0]     w_span;
    logic            w_overrun;
    logic            w_beat_acc;
    logic            w_we;
    logic [AW-1:0]   w_rd_addr;
    logic [31:0]     w_rd_word;

    // Address decode and burst range check at begin-transaction.
    assign w_addr_word = {2'b00, sb_address_data_i[31:2]};
    assign w_sel       = sb_begin_transaction_i && (w_addr_word >= LO_WORD) && (w_addr_word < HI_WORD);
    assign w_in_idx    = AW'(w_addr_word - LO_WORD);
    assign w_beats     = {1'b0, sb_burst_size_i} + 9'd1;
    assign w_span      = 16'(w_in_idx) + 16'(w_beats);
    assign w_overrun   = w_span > DEPTH16;

    // A write beat lands only while in range and not aborted by bus error.
    assign w_beat_acc  = sb_data_valid_i && !r_busy;
    assign w_we        = (r_state == WR_DATA) && w_beat_acc && (r_left != 9'd0) && !sb_error_i;

    // In IDLE the read port looks at the incoming address so a latency of
    // one can still present the first beat right after begin.
    assign w_rd_addr   = (r_state == IDLE) ? w_in_idx : r_idx;

    // Byte-lane memories: per-lane write enable, registered read.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_q;

            // Lane write on accepted beat and unconditional registered read.
            always_ff @(posedge sb_clock_i) begin
                if (w_we && r_be[gi]) begin
                    r_mem[r_idx] <= sb_address_data_i[8*gi +: 8];
                end
                r_q <= r_mem[w_rd_addr];
            end

            assign w_rd_word[8*gi +: 8] = r_q;
        end
    endgenerate

    // Transaction FSM with registered bus outputs.
    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_left  <= 9'd0;
            r_cnt   <= 4'd0;
            r_be    <= 4'd0;
            r_dv    <= 1'b0;
            r_end   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_dv   <= 1'b0;
            r_end  <= 1'b0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
            if ((r_state != IDLE) && sb_error_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_sel) begin
                            r_be <= sb_byte_enables_i;
                            if (w_overrun) begin
                                r_state <= ERR;
                                r_err   <= 1'b1;
                            end else if (sb_read_n_write_i) begin
                                if (READ_LATENCY == 1) begin
                                    r_state <= RD_DATA;
                                    r_dv    <= 1'b1;
                                    r_idx   <= w_in_idx + AW'(1);
                                    r_left  <= w_beats - 9'd1;
                                end else begin
                                    r_state <= RD_WAIT;
                                    r_cnt   <= WAIT_INIT;
                                    r_idx   <= w_in_idx;
                                    r_left  <= w_beats;
                                end
                            end else begin
                                r_state <= WR_DATA;
                                r_idx   <= w_in_idx;
                                r_left  <= w_beats;
                            end
                        end
                    end
                    RD_WAIT: begin
                        if (r_cnt == 4'd0) begin
                            r_state <= RD_DATA;
                            r_dv    <= 1'b1;
                            r_idx   <= r_idx + AW'(1);
                            r_left  <= r_left - 9'd1;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    RD_DATA: begin
                        if (r_left == 9'd0) begin
                            r_state <= RD_END;
                            r_end   <= 1'b1;
                        end else begin
                            r_dv   <= 1'b1;
                            r_idx  <= r_idx + AW'(1);
                            r_left <= r_left - 9'd1;
                        end
                    end
                    RD_END: begin
                        r_state <= IDLE;
                    end
                    WR_DATA: begin
                        if (w_beat_acc && (r_left == 9'd0)) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else begin
                            if (w_beat_acc) begin
                                r_idx  <= r_idx + AW'(1);
                                r_left <= r_left - 9'd1;
                                r_busy <= (WR_STALL != 0);
                            end
                            if (sb_end_transaction_i) begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    ERR: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Read data is gated by its valid so the shared bus sees zero otherwise.
    assign sb_address_data_o    = {32{r_dv}} & w_rd_word;
    assign sb_data_valid_o      = r_dv;
    assign sb_end_transaction_o = r_end;
    assign sb_busy_o            = r_busy;
    assign sb_error_o           = r_err;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Testbench for bus_sram_slave: two slaves on an OR'd bus, one without and
// one with write stall, driven by a table of transactions plus hand-written
// multi-cycle sequences. Expected beats/pulses go into queues at drive time
// and are consumed by a monitor sampling on the falling edge.
module tb_bus_sram_slave;

    localparam int RL     = 2;
    localparam int R_OK   = 0;
    localparam int R_ERR  = 1;
    localparam int R_NONE = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } beat_t;

    typedef struct {
        bit          rnw;
        logic [31:0] addr;
        logic [7:0]  burst;
        logic [3:0]  be;
        logic [31:0] d0;
        logic [31:0] stp;
        int          resp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        beg;
    logic        endt;
    logic        dvi;
    logic        rnw;
    logic [31:0] ad;
    logic [3:0]  bei;
    logic [7:0]  bsz;
    logic        erri;

    logic [31:0] a_data, b_data;
    logic        a_dv, b_dv, a_end, b_end, a_busy, b_busy, a_err, b_err;

    logic [31:0] bus_data;
    logic        bus_dv, bus_end, bus_busy, bus_err;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 0;
    beat_t q_rd[$];
    int    q_ev[3][$];
    string ev_name[3] = '{"busy", "error", "end"};
    vec_t  tbl[$];

    assign bus_data = a_data | b_data;
    assign bus_dv   = a_dv | b_dv;
    assign bus_end  = a_end | b_end;
    assign bus_busy = a_busy | b_busy;
    assign bus_err  = a_err | b_err;

    bus_sram_slave #(
        .BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(256), .READ_LATENCY(RL), .WR_STALL(0)
    ) u_dut (
        .sb_clock_i(clk), .sb_reset_n_i(rst_n),
        .sb_begin_transaction_i(beg), .sb_end_transaction_i(endt),
        .sb_data_valid_i(dvi), .sb_read_n_write_i(rnw),
        .sb_address_data_i(ad), .sb_byte_enables_i(bei),
        .sb_burst_size_i(bsz), .sb_error_i(erri),
        .sb_address_data_o(a_data), .sb_data_valid_o(a_dv),
        .sb_end_transaction_o(a_end), .sb_busy_o(a_busy), .sb_error_o(a_err)
    );

    bus_sram_slave #(
        .BASE_ADDR(32'h0000_2000), .DEPTH_WORDS(256), .READ_LATENCY(RL), .WR_STALL(1)
    ) u_dut_stall (
        .sb_clock_i(clk), .sb_reset_n_i(rst_n),
        .sb_begin_transaction_i(beg), .sb_end_transaction_i(endt),
        .sb_data_valid_i(dvi), .sb_read_n_write_i(rnw),
        .sb_address_data_i(ad), .sb_byte_enables_i(bei),
        .sb_burst_size_i(bsz), .sb_error_i(erri),
        .sb_address_data_o(b_data), .sb_data_valid_o(b_dv),
        .sb_end_transaction_o(b_end), .sb_busy_o(b_busy), .sb_error_o(b_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string name);
        check(name, 32'(q_rd.size() + q_ev[0].size() + q_ev[1].size() + q_ev[2].size()), 32'd0);
    endtask

    // Monitor: every asserted output must match the head of its queue.
    always @(negedge clk) begin : monitor
        beat_t    b;
        bit [2:0] ev;
        if (mon_en) begin
            if (bus_dv) begin
                if (q_rd.size() == 0) begin
                    check("rd_beat_unexpected", 32'd1, 32'd0);
                end else begin
                    b = q_rd.pop_front();
                    check("rd_data", bus_data, b.data);
                    check("rd_cycle", 32'(cyc), 32'(b.cyc));
                end
            end else begin
                check("idle_data_zero", bus_data, 32'd0);
            end
            ev = {bus_end, bus_err, bus_busy};
            for (int k = 0; k < 3; k++) begin
                if (ev[k]) begin
                    if (q_ev[k].size() == 0) check({ev_name[k], "_unexpected"}, 32'd1, 32'd0);
                    else check({ev_name[k], "_cycle"}, 32'(cyc), 32'(q_ev[k].pop_front()));
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [7:0] burst,
                           input logic [31:0] d0, input logic [31:0] stp, input int resp);
        int    t;
        int    last;
        beat_t bt;
        step();
        beg = 1; rnw = 1; ad = addr; bsz = burst; t = cyc;
        if (resp == R_OK) begin
            for (int i = 0; i <= int'(burst); i++) begin
                bt.data = d0 + stp * 32'(i);
                bt.cyc  = t + RL + i;
                q_rd.push_back(bt);
            end
            q_ev[2].push_back(t + RL + int'(burst) + 1);
            last = t + RL + int'(burst) + 2;
        end else if (resp == R_ERR) begin
            q_ev[1].push_back(t + 1);
            last = t + 2;
        end else begin
            last = t + RL + int'(burst) + 2;
        end
        step();
        beg = 0; rnw = 0; ad = 0; bsz = 0;
        while (cyc < last) step();
        drain_check("rd_drain");
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] burst, input logic [3:0] be,
                            input logic [31:0] d0, input logic [31:0] stp, input int nsend, input int resp);
        int guard;
        bit stall;
        stall = (addr >= 32'h2000);
        step();
        beg = 1; rnw = 0; ad = addr; bei = be; bsz = burst;
        if (resp == R_ERR) q_ev[1].push_back(cyc + 1);
        step();
        beg = 0; bei = 0; bsz = 0; ad = 0;
        if (resp != R_ERR) begin
            for (int i = 0; i < nsend; i++) begin
                dvi = 1;
                ad  = d0 + stp * 32'(i);
                if (i > int'(burst)) begin
                    q_ev[1].push_back(cyc + 1);
                    step();
                    break;
                end
                if (stall) q_ev[0].push_back(cyc + 1);
                step();
                guard = 0;
                while (bus_busy && guard < 3) begin
                    step();
                    guard++;
                end
                check("wr_busy_bound", 32'(guard < 3), 32'd1);
            end
            dvi = 0; ad = 0; endt = 1;
            step();
            endt = 0;
        end
        step();
        drain_check("wr_drain");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int    t;
        beat_t bt;
        clk = 0; rst_n = 0;
        beg = 0; endt = 0; dvi = 0; rnw = 0; ad = 0; bei = 0; bsz = 0; erri = 0;

        #12;
        check("rst_data", bus_data, 32'd0);
        check("rst_dv", 32'(bus_dv), 32'd0);
        check("rst_end", 32'(bus_end), 32'd0);
        check("rst_busy", 32'(bus_busy), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        step(); step();
        rst_n = 1;
        mon_en = 1;

        //              rnw   addr          burst   be     d0            step          resp
        tbl.push_back('{1'b0, 32'h0000_1000, 8'd0,   4'hF, 32'hDEADBEEF, 32'h0,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_1000, 8'd0,   4'h0, 32'hDEADBEEF, 32'h0,        R_OK});
        tbl.push_back('{1'b0, 32'h0000_1010, 8'd3,   4'hF, 32'h11111111, 32'h11111111, R_OK});
        tbl.push_back('{1'b1, 32'h0000_1010, 8'd3,   4'h0, 32'h11111111, 32'h11111111, R_OK});
        tbl.push_back('{1'b0, 32'h0000_1000, 8'd0,   4'hF, 32'hFFFFFFFF, 32'h0,        R_OK});
        tbl.push_back('{1'b0, 32'h0000_1000, 8'd0,   4'h5, 32'hAABBCCDD, 32'h0,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_1000, 8'd0,   4'h0, 32'hFFBBFFDD, 32'h0,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_1003, 8'd0,   4'h0, 32'hFFBBFFDD, 32'h0,        R_OK});
        tbl.push_back('{1'b0, 32'h0000_2000, 8'd0,   4'hF, 32'hFFFFFFFF, 32'h0,        R_OK});
        tbl.push_back('{1'b0, 32'h0000_2000, 8'd0,   4'h5, 32'hAABBCCDD, 32'h0,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_2000, 8'd0,   4'h0, 32'hFFBBFFDD, 32'h0,        R_OK});
        tbl.push_back('{1'b0, 32'h0000_2010, 8'd2,   4'hF, 32'h01020304, 32'h01010101, R_OK});
        tbl.push_back('{1'b1, 32'h0000_2010, 8'd2,   4'h0, 32'h01020304, 32'h01010101, R_OK});
        tbl.push_back('{1'b0, 32'h0000_1014, 8'd0,   4'h8, 32'h77000000, 32'h0,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_1014, 8'd0,   4'h0, 32'h77222222, 32'h0,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_0FFC, 8'd0,   4'h0, 32'h0,        32'h0,        R_NONE});
        tbl.push_back('{1'b1, 32'h0000_1400, 8'd0,   4'h0, 32'h0,        32'h0,        R_NONE});
        tbl.push_back('{1'b1, 32'h0000_13FC, 8'd1,   4'h0, 32'h0,        32'h0,        R_ERR});
        tbl.push_back('{1'b0, 32'h0000_13F8, 8'd2,   4'hF, 32'h0,        32'h0,        R_ERR});
        tbl.push_back('{1'b0, 32'h0000_13FC, 8'd0,   4'hF, 32'hCAFEF00D, 32'h0,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_13FC, 8'd0,   4'h0, 32'hCAFEF00D, 32'h0,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_1004, 8'd255, 4'h0, 32'h0,        32'h0,        R_ERR});
        tbl.push_back('{1'b0, 32'h0000_1000, 8'd255, 4'hF, 32'h10000000, 32'h1,        R_OK});
        tbl.push_back('{1'b1, 32'h0000_1000, 8'd255, 4'h0, 32'h10000000, 32'h1,        R_OK});

        foreach (tbl[n]) begin
            if (tbl[n].rnw) do_read(tbl[n].addr, tbl[n].burst, tbl[n].d0, tbl[n].stp, tbl[n].resp);
            else do_write(tbl[n].addr, tbl[n].burst, tbl[n].be, tbl[n].d0, tbl[n].stp,
                          int'(tbl[n].burst) + 1, tbl[n].resp);
        end

        // Data-valid beyond the burst length: first beat kept, second flagged.
        do_write(32'h1020, 8'd0, 4'hF, 32'h12345678, 32'h0, 2, R_OK);
        do_read(32'h1020, 8'd0, 32'h12345678, 32'h0, R_OK);
        do_read(32'h1024, 8'd0, 32'h10000009, 32'h0, R_OK);

        // Early end of a 4-beat write after two beats.
        do_write(32'h1030, 8'd3, 4'hF, 32'hA0A0A0A0, 32'h1, 2, R_OK);
        do_read(32'h1030, 8'd1, 32'hA0A0A0A0, 32'h1, R_OK);
        do_read(32'h1038, 8'd1, 32'h1000000E, 32'h1, R_OK);

        // Bus error during beat 2 of an 8-beat read.
        step();
        beg = 1; rnw = 1; ad = 32'h1000; bsz = 8'd7; t = cyc;
        bt.data = 32'h10000000; bt.cyc = t + RL;     q_rd.push_back(bt);
        bt.data = 32'h10000001; bt.cyc = t + RL + 1; q_rd.push_back(bt);
        step();
        beg = 0; rnw = 0; ad = 0; bsz = 0;
        step();
        step();
        erri = 1;
        step();
        erri = 0;
        repeat (10) step();
        drain_check("abort_drain");
        do_read(32'h1008, 8'd0, 32'h10000002, 32'h0, R_OK);

        // Reset in the middle of a stalled write burst.
        step();
        beg = 1; rnw = 0; ad = 32'h2040; bei = 4'hF; bsz = 8'd3;
        step();
        beg = 0; bei = 0; bsz = 0; dvi = 1; ad = 32'hB0000000;
        q_ev[0].push_back(cyc + 1);
        step();
        step();
        ad = 32'hB0000001;
        step();
        check("busy_before_reset", 32'(bus_busy), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("rst_mid_data", bus_data, 32'd0);
        check("rst_mid_dv", 32'(bus_dv), 32'd0);
        check("rst_mid_end", 32'(bus_end), 32'd0);
        check("rst_mid_busy", 32'(bus_busy), 32'd0);
        check("rst_mid_err", 32'(bus_err), 32'd0);
        dvi = 0; ad = 0;
        q_ev[0].delete();
        step();
        step();
        rst_n = 1;
        do_read(32'h2040, 8'd1, 32'hB0000000, 32'h1, R_OK);

        repeat (3) step();
        drain_check("final_drain");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_sram_slave.md
# bus_sram_slave

On-chip memory target for the shared system bus, sitting downstream of the bus arbiter and answering burst transactions issued by masters such as the JTAG debug interface (`jtag_if`). It decodes a fixed address window and serves single or burst reads and writes from an internal word array. It raises bus error for illegal accesses. Its outputs are zero whenever it is not driving, so they can be OR'd onto the shared bus like every other agent.

## Interface
- BASE_ADDR, 32'h0000_1000: byte base address of the window; aligned to the window size.
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 16..4096.
- READ_LATENCY, 2: cycles from begin-transaction cycle to first read beat; 1..15.
- WR_STALL, 0: if 1, `sb_busy_o` is asserted for one cycle after every accepted write beat.

- sb_clock_i  in  1  system bus clock; all logic rising-edge.
- sb_reset_n_i  in  1  asynchronous, active-low reset.
- sb_begin_transaction_i  in  1  start of transaction; address, control and burst fields are valid this cycle.
- sb_end_transaction_i  in  1  OR'd bus end-transaction.
- sb_data_valid_i  in  1  OR'd bus data-valid.
- sb_read_n_write_i  in  1  1 = read, 0 = write; sampled at begin.
- sb_address_data_i  in  32  address at begin, write data during write beats.
- sb_byte_enables_i  in  4  write byte lanes; sampled at begin and applied to every beat.
- sb_burst_size_i  in  8  beats minus one; sampled at begin.
- sb_error_i  in  1  OR'd bus error (arbiter or other agent).
- sb_address_data_o  out  32  read data; 0 when not driving.
- sb_data_valid_o  out  1  read beat valid.
- sb_end_transaction_o  out  1  read transaction complete.
- sb_busy_o  out  1  write stall.
- sb_error_o  out  1  one-cycle bus error.

## Operation
- States: IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, ERR.
- IDLE:
  - Selection: on `sb_begin_transaction_i`, the block is selected if `addr[31:2]` lies within `[BASE_ADDR>>2, (BASE_ADDR>>2)+DEPTH_WORDS)`.
  - Unselected transactions are ignored; outputs stay 0.
  - Latched at begin: word index `(addr-BASE_ADDR)>>2`, `beats = burst_size+1` (9-bit, 1..256), direction, byte enables.
  - `addr[1:0]` is ignored.
- Error check: a selected burst with `index+beats > DEPTH_WORDS` goes to ERR. Bursts never wrap inside the window.
- ERR: `sb_error_o`=1 for exactly one cycle, then IDLE. No memory access is performed.
- Reads:
  - IDLE → RD_WAIT, which counts READ_LATENCY-1 further cycles before entering RD_DATA.
  - RD_DATA drives one beat per cycle: `sb_data_valid_o`=1, `sb_address_data_o`=mem[index], index+1, beat counter −1. No gaps between beats.
  - After the last beat, the block enters RD_END: `sb_end_transaction_o`=1 for one cycle, then IDLE.
- Writes:
  - IDLE → WR_DATA.
  - A beat is accepted when `sb_data_valid_i` && !`sb_busy_o`. For each accepted beat, byte lane k of mem[index] is written with data[8k+7:8k] when `byte_enables[k]`; then index+1.
  - With WR_STALL=1, `sb_busy_o` is asserted the cycle after each accepted beat. The master holds its data and data-valid while busy.
  - `sb_end_transaction_i` returns the block to IDLE. If this comes early, beats already written remain.
  - A data-valid beyond the latched beat count is not written; it triggers ERR.
- `sb_error_i` in any non-IDLE state aborts: next state IDLE, all outputs 0 from the next cycle, and no further writes.
- `sb_begin_transaction_i` outside IDLE is ignored. The arbiter guarantees exclusivity.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset (async assert, synchronous deassert upstream):
  - State → IDLE.
  - All outputs 0 immediately: `sb_address_data_o`=0, `sb_data_valid_o`=0, `sb_end_transaction_o`=0, `sb_busy_o`=0, `sb_error_o`=0.
  - Reset mid-burst truncates the burst with no end-transaction.
- All outputs are registered; none is a combinational function of inputs.
- Read cycle map (begin in cycle T):
  - First beat valid in cycle T+READ_LATENCY.
  - Last beat in cycle T+READ_LATENCY+beats-1.
  - `sb_end_transaction_o` in the following cycle.
- Write: the beat presented in cycle W is committed at the W edge and is readable by a transaction beginning in W+1.
- Error: `sb_error_o` is asserted in cycle T+1 for a bad begin. For an overrun beat in cycle W, it is asserted in W+1.
- Abort: `sb_error_i` sampled in cycle E means outputs are 0 in cycle E+1.

## Test plan
- Preload mem[0]=32'hDEAD_BEEF; read at 0x1000, burst_size 0, READ_LATENCY 2 → one data-valid with DEADBEEF at T+2, end-transaction at T+3, no error.
- Write 4 beats 0x11111111..0x44444444 to 0x1010 with enables 4'hF, then read the same burst → data returned in order, contiguous valid beats, end-transaction one cycle after the last beat.
- Write 0xAABBCCDD with enables 4'b0101 over 0xFFFFFFFF at 0x1000 → readback 0xFFBBFFDD. Repeat with WR_STALL=1 and data held during busy → same result, with busy high one cycle per beat.
- Read at 0x0FFC, and at 0x1000+4*DEPTH_WORDS → no response, outputs 0. Read at 0x13FC with burst_size 1 (DEPTH 256) → `sb_error_o` pulse at T+1, no data-valid.
- Assert `sb_error_i` during beat 2 of an 8-beat read → data-valid low from the next cycle, no end-transaction, IDLE. A following single read succeeds.
- Deassert `sb_reset_n_i` mid-write-burst → all outputs 0 immediately. After release, a new read returns the words committed before reset.
